// File: rtl/pwm_bank_pkg.sv
// Shared constants and types for the PWM bank: register map, CTRL bit
// positions, shadow-settings structs and a small counter helper.
package pwm_bank_pkg;

    localparam int OFF_CTRL      = 0;
    localparam int OFF_PRESC     = 1;
    localparam int OFF_TOP       = 2;
    localparam int OFF_DUTY      = 3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_CHEN_LSB = 1;
    localparam int CTRL_INV_LSB  = 5;
    localparam int MAX_CH        = 4;

    typedef struct packed {
        logic [7:0] presc;
        logic [7:0] top;
    } tim_cfg_t;

    typedef struct packed {
        logic [7:0] duty;
        logic       en;
        logic       inv;
    } ch_cfg_t;

    // Next value of a wrapping up-counter.
    function automatic logic [7:0] count_next(input logic [7:0] cnt, input logic wrap);
        logic [7:0] nxt;
        if (wrap) begin
            nxt = 8'd0;
        end else begin
            nxt = cnt + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Register-window input and PWM status/output bundle between the register
// file side (master) and the PWM bank (slave).
interface pwm_bank_if #(
    parameter int NREGS = 16,
    parameter int NCH   = 2
);
    logic [8*NREGS-1:0] registers_packed;
    logic [NCH-1:0]     pwm;
    logic               period_start;
    logic               running;

    modport master (output registers_packed, input pwm, input period_start, input running);
    modport slave  (input registers_packed, output pwm, output period_start, output running);
endinterface

// File: rtl/pwm_bank_channel.sv
// One PWM channel: shadowed duty/enable/invert, compare against the shared
// period counter, registered glitch-free output.
module pwm_bank_channel import pwm_bank_pkg::*; (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic       active,
    input  logic [7:0] cnt,
    input  ch_cfg_t    cfg_in,
    output logic       pwm
);

    ch_cfg_t cfg_q;
    ch_cfg_t cfg_d;
    logic    pwm_q;
    logic    pwm_d;
    logic    raw_s;

    // Shadow update and compare; inactive channels sit at their invert level.
    always_comb begin
        if (load) begin
            cfg_d = cfg_in;
        end else begin
            cfg_d = cfg_q;
        end
        raw_s = cfg_q.en && active && (cnt < cfg_q.duty);
        pwm_d = raw_s ^ cfg_q.inv;
    end

    // Shadow and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_bank_checker.sv
// Parameter sanity and protocol invariants for pwm_bank.
module pwm_bank_checker import pwm_bank_pkg::*; #(
    parameter int NREGS    = 16,
    parameter int BASE_REG = 0,
    parameter int NCH      = 2
) (
    input logic clock,
    input logic reset_n,
    input logic period_start,
    input logic running
);

    // Checks sampled on every clock outside reset.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (NCH >= 1 && NCH <= MAX_CH && BASE_REG + OFF_DUTY + NCH <= NREGS)
                else $error("pwm_bank: illegal NCH/BASE_REG/NREGS combination");
            assert (!period_start || running)
                else $error("pwm_bank: period_start while not running");
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// PWM bank top: decodes its register window, runs the shared prescaler and
// period counter, and loads channel shadows only at period boundaries.
module pwm_bank import pwm_bank_pkg::*; #(
    parameter int NREGS    = 16,
    parameter int BASE_REG = 0,
    parameter int NCH      = 2
) (
    input  logic      clock,
    input  logic      reset_n,
    pwm_bank_if.slave bus
);

    logic [7:0]     ctrl_s;
    tim_cfg_t       tim_reg_s;
    logic           ctrl_en_s;
    logic           tick_s;
    logic           boundary_s;
    logic           load_s;
    logic           active_s;
    logic           regs_unused_s;
    logic [NCH-1:0] pwm_s;

    tim_cfg_t   tim_sh_q, tim_sh_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       running_q, running_d;
    logic       period_start_q, period_start_d;

    // Register window decode.
    always_comb begin
        ctrl_s          = bus.registers_packed[8*(BASE_REG+OFF_CTRL) +: 8];
        tim_reg_s.presc = bus.registers_packed[8*(BASE_REG+OFF_PRESC) +: 8];
        tim_reg_s.top   = bus.registers_packed[8*(BASE_REG+OFF_TOP) +: 8];
        ctrl_en_s       = ctrl_s[CTRL_EN_BIT];
        regs_unused_s   = ^bus.registers_packed;
    end

    // Tick, boundary and shadow-load strobes. Shadows track the registers
    // continuously whenever the bank is (or is about to be) idle.
    always_comb begin
        tick_s     = running_q && (pcnt_q == tim_sh_q.presc);
        boundary_s = tick_s && (cnt_q == tim_sh_q.top);
        load_s     = boundary_s || !running_q || !ctrl_en_s;
        active_s   = ctrl_en_s && running_q;
    end

    // Next state for counters, timing shadows and status flags.
    always_comb begin
        running_d      = ctrl_en_s;
        period_start_d = ctrl_en_s && load_s;
        if (load_s) begin
            tim_sh_d = tim_reg_s;
        end else begin
            tim_sh_d = tim_sh_q;
        end
        if (!active_s) begin
            pcnt_d = 8'd0;
            cnt_d  = 8'd0;
        end else if (tick_s) begin
            pcnt_d = 8'd0;
            cnt_d  = count_next(cnt_q, boundary_s);
        end else begin
            pcnt_d = count_next(pcnt_q, 1'b0);
            cnt_d  = cnt_q;
        end
    end

    // Timing state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tim_sh_q       <= '0;
            pcnt_q         <= 8'd0;
            cnt_q          <= 8'd0;
            running_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            tim_sh_q       <= tim_sh_d;
            pcnt_q         <= pcnt_d;
            cnt_q          <= cnt_d;
            running_q      <= running_d;
            period_start_q <= period_start_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_cfg_t cfg_s;
        assign cfg_s.duty = bus.registers_packed[8*(BASE_REG+OFF_DUTY+i) +: 8];
        assign cfg_s.en   = ctrl_s[CTRL_CHEN_LSB+i];
        // CTRL has no invert bit for channel 3; it never inverts.
        if (CTRL_INV_LSB + i < 8) begin : g_inv
            assign cfg_s.inv = ctrl_s[CTRL_INV_LSB+i];
        end else begin : g_noinv
            assign cfg_s.inv = 1'b0;
        end

        pwm_bank_channel u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (load_s),
            .active  (active_s),
            .cnt     (cnt_q),
            .cfg_in  (cfg_s),
            .pwm     (pwm_s[i])
        );
    end

    pwm_bank_checker #(
        .NREGS    (NREGS),
        .BASE_REG (BASE_REG),
        .NCH      (NCH)
    ) u_chk (
        .clock        (clock),
        .reset_n      (reset_n),
        .period_start (period_start_q),
        .running      (running_q)
    );

    assign bus.pwm          = pwm_s;
    assign bus.period_start = period_start_q;
    assign bus.running      = running_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: reset, duty patterns, boundary shadowing,
// invert/disable behaviour and asynchronous reset mid-period.
module tb_pwm_bank;

    localparam int NREGS    = 16;
    localparam int BASE_REG = 0;
    localparam int NCH      = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    pwm_bank_if #(.NREGS(NREGS), .NCH(NCH)) bus ();

    pwm_bank #(.NREGS(NREGS), .BASE_REG(BASE_REG), .NCH(NCH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic set_reg(input int idx, input logic [7:0] val);
        bus.registers_packed[8*(BASE_REG+idx) +: 8] = val;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Compares {pwm[1], pwm[0], period_start, running}.
    task automatic check(input string tag, input logic [1:0] p, input logic ps, input logic run);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {bus.pwm, bus.period_start, bus.running};
        exp = {p, ps, run};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {pwm,ps,run}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic restart(input logic [7:0] idle_ctrl, input logic [7:0] run_ctrl);
        set_reg(0, idle_ctrl);
        step();
        step();
        set_reg(0, run_ctrl);
        step();
    endtask

    initial begin
        logic p0;
        logic p1;
        logic ps;

        // T1: reset with non-zero registers
        bus.registers_packed = '0;
        set_reg(0, 8'h23);
        set_reg(1, 8'd0);
        set_reg(2, 8'd9);
        set_reg(3, 8'd3);
        step();
        step();
        check("T1 reset", 2'b00, 1'b0, 1'b0);

        // T2: PRESC=0, TOP=9, DUTY0=3, DUTY1=7, both channels on
        set_reg(0, 8'h07);
        set_reg(4, 8'd7);
        step();
        check("T1 reset held", 2'b00, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        check("T2 first", 2'b00, 1'b1, 1'b1);
        for (int k = 2; k <= 31; k++) begin
            step();
            p0 = ((k - 2) % 10) < 3;
            p1 = ((k - 2) % 10) < 7;
            ps = ((k - 1) % 10) == 0;
            check($sformatf("T2 k=%0d", k), {p1, p0}, ps, 1'b1);
        end

        // T3: PRESC=1, TOP=3, DUTY0=0 then 5 mid-period
        set_reg(1, 8'd1);
        set_reg(2, 8'd3);
        set_reg(3, 8'd0);
        restart(8'h00, 8'h03);
        check("T3 first", 2'b00, 1'b1, 1'b1);
        for (int k = 2; k <= 24; k++) begin
            step();
            p0 = (k >= 10);
            ps = ((k - 1) % 8) == 0;
            check($sformatf("T3 k=%0d", k), {1'b0, p0}, ps, 1'b1);
            if (k == 4) set_reg(3, 8'd5);
        end

        // T4: TOP 9->4, DUTY0 3->2 written mid-period
        set_reg(1, 8'd0);
        set_reg(2, 8'd9);
        set_reg(3, 8'd3);
        restart(8'h00, 8'h03);
        check("T4 first", 2'b00, 1'b1, 1'b1);
        for (int k = 2; k <= 30; k++) begin
            step();
            if (k <= 11) begin
                p0 = (k >= 2) && (k <= 4);
                ps = (k == 11);
            end else begin
                p0 = ((k - 12) % 5) < 2;
                ps = ((k - 11) % 5) == 0;
            end
            check($sformatf("T4 k=%0d", k), {1'b0, p0}, ps, 1'b1);
            if (k == 5) begin
                set_reg(2, 8'd4);
                set_reg(3, 8'd2);
            end
        end

        // T5: inverted ch0, disable mid active phase, then re-enable
        set_reg(2, 8'd9);
        set_reg(3, 8'd3);
        restart(8'h22, 8'h23);
        check("T5 first", 2'b01, 1'b1, 1'b1);
        step();
        check("T5 k=2", 2'b00, 1'b0, 1'b1);
        step();
        check("T5 k=3", 2'b00, 1'b0, 1'b1);
        set_reg(0, 8'h22);
        step();
        check("T5 disable", 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("T5 idle %0d", k), 2'b01, 1'b0, 1'b0);
        end
        set_reg(0, 8'h23);
        step();
        check("T5 re-enable", 2'b01, 1'b1, 1'b1);
        for (int k = 2; k <= 12; k++) begin
            step();
            p0 = !(((k - 2) % 10) < 3);
            ps = (k == 11);
            check($sformatf("T5r k=%0d", k), {1'b0, p0}, ps, 1'b1);
        end

        // T6: asynchronous reset pulse mid-period
        restart(8'h02, 8'h03);
        check("T6 first", 2'b00, 1'b1, 1'b1);
        step();
        step();
        check("T6 high", 2'b01, 1'b0, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("T6 async clear", 2'b00, 1'b0, 1'b0);
        step();
        check("T6 in reset", 2'b00, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        check("T6 restart", 2'b00, 1'b1, 1'b1);
        for (int k = 2; k <= 12; k++) begin
            step();
            p0 = ((k - 2) % 10) < 3;
            ps = (k == 11);
            check($sformatf("T6 k=%0d", k), {1'b0, p0}, ps, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
